mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the fetch stage (instruction reads) and the

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle around the unified-memory arbiter
// Ports (grouped signals):
//   fetch  : if_req, if_addr in; if_ack, if_rdata out (arbiter view)
//   data   : d_req, d_we, d_size, d_addr, d_wdata in; d_ack, d_rdata out
//   memory : mem_req, mem_we, mem_size, mem_addr, mem_wdata out; mem_done, mem_rdata in
// master = arbiter side, slave = requesters plus memory side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_done, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_done, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data access
// Ports:
//   clk   in  clock, all state on rising edge
//   reset in  synchronous active-high reset
//   bus   mem_port_arbiter_if.master: fetch/data request-ack pairs and the memory transaction port
// Data requests win unless fetch has waited STARVE_LIMIT data grants. One transaction in flight;
// acks are single-cycle pulses coincident with mem_done. Optional one-entry fetch buffer is
// enabled by defining FETCH_BUF_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arbState;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arbState          state;
    logic             memReq;
    logic             memWe;
    logic [2:0]       memSize;
    logic [31:0]      memAddr;
    logic [31:0]      memWdata;
    logic [CNT_W-1:0] starveCnt;
    logic             bufHit;
    logic [31:0]      hitWord;
    logic             fetchCand;
    logic             forceFetch;
    logic             dataWin;
    logic             fetchWin;
    logic             memAckI;
    logic             memAckD;

    // a buffered fetch never competes for the memory port
    assign fetchCand  = bus.if_req & ~bufHit;
    assign forceFetch = fetchCand & (starveCnt == LIMIT);
    assign dataWin    = (state == IDLE) & bus.d_req & ~forceFetch;
    assign fetchWin   = (state == IDLE) & fetchCand & ~dataWin;

    // acks are suppressed while reset is asserted so a completion racing reset is dropped
    assign memAckI = ~reset & (state == BUSY_I) & bus.mem_done;
    assign memAckD = ~reset & (state == BUSY_D) & bus.mem_done;

    assign bus.if_ack   = memAckI | bufHit;
    assign bus.if_rdata = memAckI ? bus.mem_rdata : bufHit ? hitWord : '0;
    assign bus.d_ack    = memAckD;
    assign bus.d_rdata  = memAckD ? bus.mem_rdata : '0;

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_size  = memSize;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;

`ifdef FETCH_BUF_EN
    logic        bufValid;
    logic [29:0] bufTag;
    logic [31:0] bufWord;

    assign bufHit  = ~reset & (state == IDLE) & bus.if_req & bufValid & (bufTag == bus.if_addr[31:2]);
    assign hitWord = bufWord;

    // a store granted to the buffered word invalidates it so modified code is refetched
    always_ff @(posedge clk) begin
        if (reset) begin
            bufValid <= 1'b0;
            bufTag   <= '0;
            bufWord  <= '0;
        end else if (memAckI) begin
            bufValid <= 1'b1;
            bufTag   <= memAddr[31:2];
            bufWord  <= bus.mem_rdata;
        end else if (dataWin && bus.d_we && bus.d_addr[31:2] == bufTag) begin
            bufValid <= 1'b0;
        end
    end
`else
    assign bufHit  = 1'b0;
    assign hitWord = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memSize   <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            starveCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataWin) begin
                        state    <= BUSY_D;
                        memReq   <= 1'b1;
                        memWe    <= bus.d_we;
                        memSize  <= bus.d_size;
                        memAddr  <= bus.d_addr;
                        memWdata <= bus.d_wdata;
                    end else if (fetchWin) begin
                        state    <= BUSY_I;
                        memReq   <= 1'b1;
                        memWe    <= 1'b0;
                        memSize  <= 3'b010;
                        memAddr  <= bus.if_addr;
                        memWdata <= '0;
                    end
                    // counts data grants that left a fetch waiting; any fetch service clears it
                    if (bufHit || fetchWin)
                        starveCnt <= '0;
                    else if (dataWin)
                        starveCnt <= !fetchCand ? '0 : (starveCnt == LIMIT) ? starveCnt : starveCnt + 1'b1;
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_done) begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end
endmodule
